// File: rtl/buff_uart_pkg.sv
// Shared UART definitions used by the buffered transmitter and receiver.
package buff_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DEF_CLOCK_FREQ = 50_000_000;
  localparam int DEF_BAUD_RATE  = 115_200;
  localparam int DEF_WIDTH      = 8;

  function automatic int calc_ticks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty; a write takes 1 cycle.
// Pushes into a full FIFO are dropped (and flagged) unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push_vld_i,
  input  logic [width-1:0]         push_dat_i,
  input  logic                     pop_vld_i,
  output logic [width-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(depth):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_vld_i && !empty_q;
  assign push_ok = push_vld_i && (!full_q || pop_ok);
  assign drop_o  = push_vld_i && !push_ok;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(depth));
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;

endmodule

// File: rtl/buff_uart_rx.sv
// Bus-readable UART receiver: 8N1 deserialiser feeding a FIFO; pop to data_valid is 1 cycle.
// No backpressure on the line: frames arriving while the FIFO is full are dropped and flagged.
module buff_uart_rx
  import buff_uart_pkg::*;
#(
  parameter int clock_freq    = DEF_CLOCK_FREQ,
  parameter int baud_rate     = DEF_BAUD_RATE,
  parameter int width         = DEF_WIDTH,
  parameter int depth         = 4,
  parameter int address_width = 8,
  parameter int rx_address    = 'd3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     rx,
  input  logic [address_width-1:0] active_address,
  input  logic                     read_enable,
  output logic [width-1:0]         data,
  output logic                     data_valid,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic [$clog2(depth):0]   rx_count,
  output logic                     overflow,
  output logic                     framing_error,
  input  logic                     clear_errors
);

  localparam int TPB = calc_ticks_per_bit(clock_freq, baud_rate);
  localparam int TW  = $clog2(TPB);
  localparam int BW  = (width > 1) ? $clog2(width) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(TPB/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TPB - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);

  logic              rx_meta_q, rx_s_q;
  uart_state_t       state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [width-1:0]  shift_q, shift_d;
  logic              push_vld, frame_err, pop_vld, drop;
  logic [width-1:0]  head_dat;
  logic [width-1:0]  data_q;
  logic              data_valid_q, overflow_q, framing_error_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_vld  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        tick_d  = '0;
      end
      START: if (tick_q == TICK_HALF) begin
        // A line back high at mid start bit is treated as a glitch.
        if (!rx_s_q) begin
          state_d = DATA;
          tick_d  = '0;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end else tick_d = tick_q + 1'b1;
      DATA: if (tick_q == TICK_LAST) begin
        shift_d[bit_q] = rx_s_q;
        tick_d         = '0;
        if (bit_q == BIT_LAST) state_d = STOP;
        else                   bit_d   = bit_q + 1'b1;
      end else tick_d = tick_q + 1'b1;
      STOP: if (tick_q == TICK_LAST) begin
        if (rx_s_q) push_vld  = 1'b1;
        else        frame_err = 1'b1;
        state_d = IDLE;
      end else tick_d = tick_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign pop_vld = read_enable && (active_address == address_width'(rx_address)) && !rx_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= IDLE;
      tick_q          <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      overflow_q      <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      tick_q          <= tick_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      data_valid_q    <= pop_vld;
      if (pop_vld) data_q <= head_dat;
      overflow_q      <= (overflow_q & ~clear_errors) | drop;
      framing_error_q <= (framing_error_q & ~clear_errors) | frame_err;
    end
  end

  sync_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push_vld_i (push_vld),
    .push_dat_i (shift_d),
    .pop_vld_i  (pop_vld),
    .head_dat_o (head_dat),
    .full_o     (rx_full),
    .empty_o    (rx_empty),
    .count_o    (rx_count),
    .drop_o     (drop)
  );

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign overflow      = overflow_q;
  assign framing_error = framing_error_q;

endmodule
